// File: rtl/dma_xfer_sequencer_if.sv
// Bus bundle between the DMA cycle sequencer and its surroundings (channel
// register file, request lines, CPU hold handshake and command strobes).
interface dma_xfer_sequencer_if #(
  parameter int N_CH = 4,
  parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic                CS_N;
  logic                cfgValid;
  logic [N_CH-1:0]     dreq;
  logic [N_CH-1:0]     chMask;
  logic [2*N_CH-1:0]   transferType;
  logic [N_CH-1:0]     blockMode;
  logic [N_CH-1:0]     autoInit;
  logic                tcIn;
  logic                READY;
  logic                EOP_IN_N;
  logic                hlda;

  logic                hrq;
  logic                aen;
  logic                adstb;
  logic [N_CH-1:0]     dack;
  logic                ior;
  logic                iow;
  logic                memr;
  logic                memw;
  logic [CH_W-1:0]     activeCh;
  logic                decrCount;
  logic                incrAddr;
  logic                reloadBase;
  logic                intEop;
  logic                timeoutErr;

  // Sequencer side
  modport master (
    input  CS_N, cfgValid, dreq, chMask, transferType, blockMode, autoInit,
           tcIn, READY, EOP_IN_N, hlda,
    output hrq, aen, adstb, dack, ior, iow, memr, memw, activeCh,
           decrCount, incrAddr, reloadBase, intEop, timeoutErr
  );

  // Environment side (register file, devices, CPU)
  modport slave (
    output CS_N, cfgValid, dreq, chMask, transferType, blockMode, autoInit,
           tcIn, READY, EOP_IN_N, hlda,
    input  hrq, aen, adstb, dack, ior, iow, memr, memw, activeCh,
           decrCount, incrAddr, reloadBase, intEop, timeoutErr
  );
endinterface

// File: rtl/dma_xfer_sequencer.sv
// 8237-style DMA timing/control sequencer: fixed-priority arbitration, HRQ/HLDA
// handshake, SI/S0/S1..S4 transfer cycle with READY wait states and timeout.
module dma_xfer_sequencer #(
  parameter int N_CH     = 4,
  parameter int WAIT_MAX = 7,
  parameter int WAIT_W   = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  dma_xfer_sequencer_if.master  bus
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [2:0] {
    ST_SI = 3'd0,
    ST_S0 = 3'd1,
    ST_S1 = 3'd2,
    ST_S2 = 3'd3,
    ST_S3 = 3'd4,
    ST_S4 = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   active_ch_q, active_ch_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              eop_seen_q, eop_seen_d;
  logic              timeout_q, timeout_d;

  logic [N_CH-1:0]   req_vec;
  logic              req_any;
  logic [CH_W-1:0]   req_idx;
  logic [1:0]        type_arr [N_CH];
  logic [1:0]        ch_type;
  logic              ch_dreq;
  logic              term;
  logic              wait_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_type
      assign type_arr[gi] = bus.transferType[2*gi +: 2];
    end
  endgenerate

  assign req_vec  = bus.dreq & ~bus.chMask;
  assign req_any  = |req_vec;
  assign ch_type  = type_arr[active_ch_q];
  assign ch_dreq  = bus.dreq[active_ch_q];
  assign wait_hit = (wait_cnt_q == WAIT_W'(WAIT_MAX - 1));
  // Terminal transfer: count exhausted, or end-of-process seen in this loop.
  assign term     = bus.tcIn | eop_seen_q | ~bus.EOP_IN_N;

  always_comb begin
    req_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_vec[i]) req_idx = CH_W'(i);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_SI;
      active_ch_q <= '0;
      wait_cnt_q  <= '0;
      eop_seen_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_ch_q <= active_ch_d;
      wait_cnt_q  <= wait_cnt_d;
      eop_seen_q  <= eop_seen_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    active_ch_d = active_ch_q;
    wait_cnt_d  = wait_cnt_q;
    eop_seen_d  = eop_seen_q;
    timeout_d   = 1'b0;

    if (state_q != ST_SI && state_q != ST_S0 && !bus.EOP_IN_N) eop_seen_d = 1'b1;

    case (state_q)
      ST_SI: begin
        if (bus.CS_N && bus.cfgValid && req_any) begin
          active_ch_d = req_idx;
          state_d     = ST_S0;
        end
      end
      ST_S0: begin
        if (bus.hlda)      state_d = ST_S1;
        else if (!ch_dreq) state_d = ST_SI;
      end
      ST_S1: begin
        wait_cnt_d = '0;
        state_d    = ST_S2;
      end
      ST_S2: state_d = ST_S3;
      ST_S3: begin
        if (bus.READY) begin
          state_d = ST_S4;
        end else if (wait_hit) begin
          timeout_d  = 1'b1;
          eop_seen_d = 1'b0;
          state_d    = ST_SI;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_S4: begin
        // Block mode keeps the bus and restrobes the same channel.
        if (!term && bus.blockMode[active_ch_q] && ch_dreq) begin
          state_d = ST_S1;
        end else begin
          eop_seen_d = 1'b0;
          state_d    = ST_SI;
        end
      end
      default: state_d = ST_SI;
    endcase
  end

  logic in_s1, in_s3, in_s4, rd_en, wr_en, dack_en;

  always_comb begin
    in_s1   = (state_q == ST_S1);
    in_s3   = (state_q == ST_S3);
    in_s4   = (state_q == ST_S4);
    dack_en = (state_q == ST_S1) || (state_q == ST_S2) || in_s3 || in_s4;
    rd_en   = (state_q == ST_S2) || in_s3;
    wr_en   = in_s3;
  end

  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_dack
      assign bus.dack[gi] = dack_en && (active_ch_q == CH_W'(gi));
    end
  endgenerate

  assign bus.hrq        = (state_q != ST_SI);
  assign bus.aen        = dack_en;
  assign bus.adstb      = in_s1;
  assign bus.ior        = rd_en && (ch_type == 2'b01);
  assign bus.memr       = rd_en && (ch_type == 2'b10);
  assign bus.memw       = wr_en && (ch_type == 2'b01);
  assign bus.iow        = wr_en && (ch_type == 2'b10);
  assign bus.activeCh   = active_ch_q;
  assign bus.decrCount  = in_s4;
  assign bus.incrAddr   = in_s4;
  assign bus.intEop     = in_s4 && term;
  assign bus.reloadBase = in_s4 && term && bus.autoInit[active_ch_q];
  assign bus.timeoutErr = timeout_q;
endmodule

// File: tb/tb_dma_xfer_sequencer.sv
// Bench for dma_xfer_sequencer: table of transactions with hand-derived pulse
// counts, random transactions against a transaction-level trace model, corner cases.
module tb_dma_xfer_sequencer;
  localparam int N_CH     = 4;
  localparam int WAIT_MAX = 7;
  localparam int WAIT_W   = 8;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  dma_xfer_sequencer_if #(.N_CH(N_CH)) bus();

  dma_xfer_sequencer #(.N_CH(N_CH), .WAIT_MAX(WAIT_MAX), .WAIT_W(WAIT_W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct packed {
    logic hrq, aen, adstb;
    logic [3:0] dack;
    logic ior, iow, memr, memw, decr, incr, reload, inteop, tmo;
  } out_t;

  typedef struct packed {
    logic ready, tc, eop_n, hlda;
    logic [3:0] dreq;
    logic chk_ch;
    out_t exp;
  } step_t;

  // One request-to-idle transaction. rl[k] = READY-low cycles in S3 of loop k;
  // tc_at / eop_at name the loop carrying terminal count / EOP (>= nx: never).
  typedef struct packed {
    logic [3:0] dreq, mask;
    logic [7:0] types;
    logic [3:0] block, autoinit;
    logic [1:0] hlda_dly;
    logic [2:0] nx;
    logic [3:0][3:0] rl;
    logic [2:0] tc_at, eop_at;
  } xact_t;

  typedef struct packed {
    xact_t x;
    logic [1:0] ch;
    logic [2:0] n_adstb, n_decr, n_eop, n_reload, n_tmo;
  } vec_t;

  step_t trace[$];
  int n_checks = 0;
  int n_fail   = 0;
  int c_adstb, c_decr, c_eop, c_reload, c_tmo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic out_t sample();
    out_t o;
    o.hrq = bus.hrq; o.aen = bus.aen; o.adstb = bus.adstb; o.dack = bus.dack;
    o.ior = bus.ior; o.iow = bus.iow; o.memr = bus.memr; o.memw = bus.memw;
    o.decr = bus.decrCount; o.incr = bus.incrAddr; o.reload = bus.reloadBase;
    o.inteop = bus.intEop; o.tmo = bus.timeoutErr;
    return o;
  endfunction

  function automatic step_t mk(input logic ready, input logic tc, input logic eop_n,
                               input logic hlda, input logic [3:0] dreq,
                               input logic chk, input out_t e);
    step_t s;
    s.ready = ready; s.tc = tc; s.eop_n = eop_n; s.hlda = hlda;
    s.dreq = dreq; s.chk_ch = chk; s.exp = e;
    return s;
  endfunction

  function automatic logic [1:0] pick_ch(input xact_t x);
    logic [1:0] ch = 2'd0;
    for (int i = 3; i >= 0; i--) if (x.dreq[i] && !x.mask[i]) ch = 2'(i);
    return ch;
  endfunction

  // Expected cycle-by-cycle waveform of a whole transaction, from the transfer rules.
  task automatic build_trace(input xact_t x);
    out_t base, o;
    logic [1:0] ch, t;
    logic tc, term, last;
    bit done = 0;
    trace.delete();
    ch = pick_ch(x);
    t  = x.types[2*ch +: 2];
    base = '0; base.hrq = 1; base.aen = 1; base.dack = 4'b0001 << ch;
    trace.push_back(mk(1, 0, 1, 0, x.dreq, 0, '0));
    for (int i = 0; i <= int'(x.hlda_dly); i++) begin
      o = '0; o.hrq = 1;
      trace.push_back(mk(1, 0, 1, (i == int'(x.hlda_dly)), x.dreq, 1, o));
    end
    for (int k = 0; k < int'(x.nx) && !done; k++) begin
      tc = (int'(x.tc_at) == k);
      o = base; o.adstb = 1;
      trace.push_back(mk(1, tc, 1, 1, x.dreq, 1, o));
      o = base; o.ior = (t == 2'b01); o.memr = (t == 2'b10);
      trace.push_back(mk(1, tc, (int'(x.eop_at) == k) ? 1'b0 : 1'b1, 1, x.dreq, 1, o));
      o.memw = (t == 2'b01); o.iow = (t == 2'b10);
      if (int'(x.rl[k]) >= WAIT_MAX) begin
        for (int j = 0; j < WAIT_MAX; j++) trace.push_back(mk(0, tc, 1, 1, x.dreq, 1, o));
        o = '0; o.tmo = 1;
        trace.push_back(mk(1, 0, 1, 0, 4'd0, 1, o));
        done = 1;
      end else begin
        for (int j = 0; j < int'(x.rl[k]); j++) trace.push_back(mk(0, tc, 1, 1, x.dreq, 1, o));
        trace.push_back(mk(1, tc, 1, 1, x.dreq, 1, o));
        term = tc || (int'(x.eop_at) == k);
        last = term || (k == int'(x.nx) - 1);
        o = base; o.decr = 1; o.incr = 1; o.inteop = term;
        o.reload = term && x.autoinit[ch];
        trace.push_back(mk(1, tc, 1, 1, last ? 4'd0 : x.dreq, 1, o));
        if (last) begin
          trace.push_back(mk(1, 0, 1, 0, 4'd0, 1, '0));
          done = 1;
        end
      end
    end
  endtask

  task automatic run_xact(input xact_t x, input string tag);
    out_t act;
    logic [1:0] ch;
    ch = pick_ch(x);
    build_trace(x);
    c_adstb = 0; c_decr = 0; c_eop = 0; c_reload = 0; c_tmo = 0;
    foreach (trace[i]) begin
      @(posedge CLK); #1;
      bus.CS_N = 1; bus.cfgValid = 1;
      bus.chMask = x.mask; bus.transferType = x.types;
      bus.blockMode = x.block; bus.autoInit = x.autoinit;
      bus.READY = trace[i].ready; bus.tcIn = trace[i].tc;
      bus.EOP_IN_N = trace[i].eop_n; bus.hlda = trace[i].hlda;
      bus.dreq = trace[i].dreq;
      @(negedge CLK);
      act = sample();
      check($sformatf("%s cyc%0d outputs", tag, i), 32'(act), 32'(trace[i].exp));
      if (trace[i].chk_ch) check($sformatf("%s cyc%0d activeCh", tag, i), 32'(bus.activeCh), 32'(ch));
      check($sformatf("%s cyc%0d dack onehot0", tag, i), 32'($onehot0(bus.dack)), 32'd1);
      check($sformatf("%s cyc%0d rd/wr exclusive", tag, i),
            32'({bus.ior & bus.iow, bus.memr & bus.memw}), 32'd0);
      c_adstb += int'(act.adstb); c_decr += int'(act.decr); c_eop += int'(act.inteop);
      c_reload += int'(act.reload); c_tmo += int'(act.tmo);
    end
  endtask

  function automatic xact_t mkx(input logic [3:0] dreq, input logic [3:0] mask,
                                input logic [7:0] types, input logic [3:0] block,
                                input logic [3:0] ai, input logic [1:0] hd,
                                input logic [2:0] nx, input logic [15:0] rl,
                                input logic [2:0] tc_at, input logic [2:0] eop_at);
    xact_t x;
    x.dreq = dreq; x.mask = mask; x.types = types; x.block = block; x.autoinit = ai;
    x.hlda_dly = hd; x.nx = nx; x.rl = rl; x.tc_at = tc_at; x.eop_at = eop_at;
    return x;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[10];
    xact_t rx;
    logic [1:0] rch;

    // dreq mask types block ai hd nx rl tc eop | ch adstb decr eop reload tmo
    tbl[0] = {mkx(4'b0100, 4'b0000, 8'h10, 4'b0000, 4'b0000, 2'd1, 3'd1, 16'h0000, 3'd7, 3'd7), 2'd2, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
    tbl[1] = {mkx(4'b1011, 4'b0001, 8'h08, 4'b0000, 4'b0000, 2'd0, 3'd1, 16'h0000, 3'd7, 3'd7), 2'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
    tbl[2] = {mkx(4'b0001, 4'b0000, 8'h02, 4'b0001, 4'b0001, 2'd0, 3'd3, 16'h0000, 3'd2, 3'd7), 2'd0, 3'd3, 3'd3, 3'd1, 3'd1, 3'd0};
    tbl[3] = {mkx(4'b0001, 4'b0000, 8'h02, 4'b0001, 4'b0000, 2'd0, 3'd3, 16'h0000, 3'd2, 3'd7), 2'd0, 3'd3, 3'd3, 3'd1, 3'd0, 3'd0};
    tbl[4] = {mkx(4'b0001, 4'b0000, 8'h01, 4'b0000, 4'b0000, 2'd0, 3'd1, 16'h0003, 3'd7, 3'd7), 2'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
    tbl[5] = {mkx(4'b0001, 4'b0000, 8'h01, 4'b0000, 4'b0000, 2'd0, 3'd1, 16'h0007, 3'd7, 3'd7), 2'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1};
    tbl[6] = {mkx(4'b1000, 4'b0000, 8'h40, 4'b1000, 4'b1000, 2'd0, 3'd3, 16'h0000, 3'd7, 3'd1), 2'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0};
    tbl[7] = {mkx(4'b0010, 4'b0000, 8'h0C, 4'b0010, 4'b0000, 2'd2, 3'd2, 16'h0000, 3'd7, 3'd7), 2'd1, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0};
    tbl[8] = {mkx(4'b0100, 4'b0000, 8'h10, 4'b0000, 4'b0100, 2'd0, 3'd1, 16'h0000, 3'd0, 3'd7), 2'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
    tbl[9] = {mkx(4'b0001, 4'b0000, 8'h01, 4'b0000, 4'b0000, 2'd0, 3'd1, 16'h0006, 3'd7, 3'd7), 2'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};

    RESET = 1; bus.CS_N = 1; bus.cfgValid = 1; bus.dreq = '0; bus.chMask = '0;
    bus.transferType = '0; bus.blockMode = '0; bus.autoInit = '0; bus.tcIn = 0;
    bus.READY = 1; bus.EOP_IN_N = 1; bus.hlda = 0;
    repeat (2) @(negedge CLK);
    check("reset outputs", 32'(sample()), 32'd0);
    check("reset activeCh", 32'(bus.activeCh), 32'd0);
    RESET = 0;

    foreach (tbl[v]) begin
      run_xact(tbl[v].x, $sformatf("vec%0d", v));
      check($sformatf("vec%0d adstb count", v), 32'(c_adstb), 32'(tbl[v].n_adstb));
      check($sformatf("vec%0d decrCount count", v), 32'(c_decr), 32'(tbl[v].n_decr));
      check($sformatf("vec%0d intEop count", v), 32'(c_eop), 32'(tbl[v].n_eop));
      check($sformatf("vec%0d reloadBase count", v), 32'(c_reload), 32'(tbl[v].n_reload));
      check($sformatf("vec%0d timeoutErr count", v), 32'(c_tmo), 32'(tbl[v].n_tmo));
      $display("vec%0d done: ch=%0d adstb=%0d decr=%0d eop=%0d reload=%0d tmo=%0d",
               v, tbl[v].ch, c_adstb, c_decr, c_eop, c_reload, c_tmo);
    end

    for (int r = 0; r < 40; r++) begin
      rx.dreq = 4'($urandom_range(1, 15));
      rx.mask = 4'($urandom_range(0, 15));
      if ((rx.dreq & ~rx.mask) == 4'd0) rx.mask = rx.mask & ~rx.dreq;
      rx.types = 8'($urandom); rx.block = 4'($urandom); rx.autoinit = 4'($urandom);
      rx.hlda_dly = 2'($urandom_range(0, 2));
      rch = pick_ch(rx);
      rx.nx = rx.block[rch] ? 3'($urandom_range(1, 4)) : 3'd1;
      for (int k = 0; k < 4; k++)
        rx.rl[k] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(7, 9)) : 4'($urandom_range(0, 6));
      rx.tc_at = 3'($urandom_range(0, 7)); rx.eop_at = 3'($urandom_range(0, 7));
      run_xact(rx, $sformatf("rnd%0d", r));
      $display("rnd%0d done: ch=%0d nx=%0d adstb=%0d decr=%0d eop=%0d tmo=%0d",
               r, rch, rx.nx, c_adstb, c_decr, c_eop, c_tmo);
    end

    // Reset in S3: outputs must drop mid-cycle, before any clock edge.
    @(posedge CLK); #1;
    bus.dreq = 4'b0100; bus.chMask = '0; bus.transferType = 8'h10; bus.hlda = 1;
    bus.READY = 0; bus.CS_N = 1; bus.cfgValid = 1; bus.tcIn = 0; bus.EOP_IN_N = 1;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check("pre-reset in S3 memw", 32'(bus.memw), 32'd1);
    #1 RESET = 1;
    #1 check("async reset outputs", 32'(sample()), 32'd0);
    check("async reset activeCh", 32'(bus.activeCh), 32'd0);
    @(negedge CLK);
    check("reset held outputs", 32'(sample()), 32'd0);
    RESET = 0; bus.CS_N = 0; bus.hlda = 0; bus.READY = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check($sformatf("CS_N low hold %0d hrq", i), 32'(bus.hrq), 32'd0);
    end
    bus.CS_N = 1; bus.cfgValid = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      check($sformatf("cfgValid low hold %0d hrq", i), 32'(bus.hrq), 32'd0);
    end
    bus.cfgValid = 1;
    @(negedge CLK);
    check("S0 entered hrq", 32'(bus.hrq), 32'd1);
    check("S0 no dack", 32'(bus.dack), 32'd0);
    bus.dreq = '0;
    @(negedge CLK);
    check("S0 dreq drop returns idle", 32'(sample()), 32'd0);
    $display("corner sequences done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
